mem_cmd_driver: RTL

MEM_CMD_DRIVER -- requirements
Module: mem_cmd_driver

---
 rtl/mem_drv_pkg.sv | 10 +
 rtl/mem_cmd_fifo.sv | 41 ++++
 rtl/mem_cmd_driver.sv | 101 ++++++++++
 3 files changed

// File: rtl/mem_drv_pkg.sv
// mem_drv_pkg: shared state, command type and defaults for the memory command driver
package mem_drv_pkg;
   localparam int MEM_WORDS_DEF = 8;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
   typedef struct packed {
      logic       write;
      logic [7:0] addr;
      logic [7:0] wdata;
   } cmd_t;
endpackage

// File: rtl/mem_cmd_fifo.sv
// mem_cmd_fifo: in-order command buffer with full/empty flags and occupancy count
module mem_cmd_fifo
   import mem_drv_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  cmd_t                   din,
   output cmd_t                   dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   cmd_t mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic do_push, do_pop;
   assign full    = count == (AW+1)'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rp];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         wp    <= do_push ? wp + 1'b1 : wp;
         rp    <= do_pop ? rp + 1'b1 : rp;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
   // storage needs no reset; pointers alone define validity
   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= din;
   end
endmodule

// File: rtl/mem_cmd_driver.sv
// mem_cmd_driver: buffers memory commands and sequences each through setup, access and response phases
module mem_cmd_driver
   import mem_drv_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int MEM_WORDS  = MEM_WORDS_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic [7:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_rdata,
   output logic       rsp_write,
   output logic       rsp_err,
   output logic       read,
   output logic       write,
   output logic       enable,
   output logic [7:0] address,
   output logic [7:0] wdata,
   input  logic [7:0] rdata
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   state_t st;
   cmd_t cr, head;
   logic full, empty, pop, oob;
   logic [CW-1:0] count;
   assign cmd_ready = !full;
   assign pop       = st == IDLE && !empty;
   assign oob       = 32'(cr.addr) >= MEM_WORDS;
   mem_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cmd_valid && cmd_ready),
      .pop   (pop),
      .din   ({cmd_write, cmd_addr, cmd_wdata}),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );
   always_comb assert (rst || full == (count == CW'(FIFO_DEPTH)));
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st        <= IDLE;
         cr        <= '0;
         read      <= 1'b0;
         write     <= 1'b0;
         enable    <= 1'b0;
         address   <= '0;
         wdata     <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_write <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         case (st)
            IDLE: if (pop) begin
               cr      <= head;
               address <= head.addr;
               wdata   <= head.wdata;
               read    <= !head.write;
               write   <= head.write;
               st      <= SETUP;
            end
            // out-of-range commands skip the access phase entirely
            SETUP: if (oob) begin
               read      <= 1'b0;
               write     <= 1'b0;
               rsp_valid <= 1'b1;
               rsp_rdata <= '0;
               rsp_write <= cr.write;
               rsp_err   <= 1'b1;
               st        <= RESP;
            end else begin
               enable <= 1'b1;
               st     <= ACCESS;
            end
            ACCESS: begin
               enable    <= 1'b0;
               read      <= 1'b0;
               write     <= 1'b0;
               rsp_valid <= 1'b1;
               rsp_rdata <= cr.write ? 8'h00 : rdata;
               rsp_write <= cr.write;
               rsp_err   <= 1'b0;
               st        <= RESP;
            end
            RESP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               st        <= IDLE;
            end
            default: st <= IDLE;
         endcase
      end
   end
endmodule
